// File: rtl/tx_link_scheduler.sv
// tx_link_scheduler: word-rate scheduler for the 8b10b transmit encoder.
// Runs a word timer off the bit clock, sends SYNC_WORDS idle words after reset,
// then shares the encoder between requester A (priority) and requester B
// (granted after MAX_BURST consecutive A words while it waits). A comma/idle
// word is forced after COMMA_INTERVAL consecutive data words.
// Ports: clk, rst (sync, active-low); a_*/b_* valid/ready byte requesters;
// enc_d_in/enc_idle/enc_nextword_enable drive the encoder; src_b flags a B word;
// sync_done goes high once the startup idle words are out.
module tx_link_scheduler #(
  parameter int WORD_CYCLES    = 10,
  parameter int SYNC_WORDS     = 4,
  parameter int COMMA_INTERVAL = 256,
  parameter int MAX_BURST      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] a_data,
  input  logic       a_valid,
  output logic       a_ready,
  input  logic [7:0] b_data,
  input  logic       b_valid,
  output logic       b_ready,
  output logic [7:0] enc_d_in,
  output logic       enc_idle,
  output logic       enc_nextword_enable,
  output logic       src_b,
  output logic       sync_done
);
  localparam int TW = WORD_CYCLES > 1 ? $clog2(WORD_CYCLES) : 1;
  localparam int SW = $clog2(SYNC_WORDS + 1);
  localparam int CW = $clog2(COMMA_INTERVAL + 1);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [TW-1:0] T_LAST = TW'(WORD_CYCLES - 1);
  localparam logic [SW-1:0] S_LAST = SW'(SYNC_WORDS - 1);
  localparam logic [CW-1:0] C_MAX  = CW'(COMMA_INTERVAL);
  localparam logic [BW-1:0] B_MAX  = BW'(MAX_BURST);
  typedef enum logic {SYNC, RUN} state_t;
  state_t        state;
  logic [TW-1:0] timer;
  logic [SW-1:0] sync_cnt;
  logic [CW-1:0] comma_cnt;
  logic [BW-1:0] burst_cnt;
  logic          slot, comma_due, take_a, take_b;
  always_comb begin
    slot      = timer == T_LAST;
    comma_due = comma_cnt == C_MAX;
    take_a    = state == RUN && !comma_due && a_valid && !(b_valid && burst_cnt == B_MAX);
    take_b    = state == RUN && !comma_due && !take_a && b_valid;
    // gated by rst so a reset landing on a slot cycle never completes a handshake
    a_ready   = rst && slot && take_a;
    b_ready   = rst && slot && take_b;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state               <= SYNC;
      timer               <= '0;
      sync_cnt            <= '0;
      comma_cnt           <= '0;
      burst_cnt           <= '0;
      enc_d_in            <= '0;
      enc_idle            <= 1'b1;
      enc_nextword_enable <= 1'b0;
      src_b               <= 1'b0;
      sync_done           <= 1'b0;
    end else begin
      enc_nextword_enable <= slot;
      timer               <= slot ? '0 : timer + 1'b1;
      if (slot) begin
        if (state == SYNC) begin
          enc_idle <= 1'b1;
          src_b    <= 1'b0;
          sync_cnt <= sync_cnt + 1'b1;
          if (sync_cnt == S_LAST) begin
            state     <= RUN;
            sync_done <= 1'b1;
          end
        end else if (take_a || take_b) begin
          enc_idle  <= 1'b0;
          src_b     <= take_b;
          enc_d_in  <= take_b ? b_data : a_data;
          comma_cnt <= comma_cnt + 1'b1;
          // burst only counts A words that were granted while B was waiting
          burst_cnt <= (take_b || !b_valid) ? '0 : burst_cnt + 1'b1;
        end else begin
          enc_idle  <= 1'b1;
          src_b     <= 1'b0;
          comma_cnt <= '0;
          // a forced comma leaves the B starvation count untouched
          if (!comma_due) burst_cnt <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_tx_link_scheduler.sv
// tb_tx_link_scheduler: directed checks of the transmit link scheduler.
module tb_tx_link_scheduler;
  logic       clk = 1'b0;
  logic       rst, rst1;
  logic [7:0] a_data, b_data, enc_d_in;
  logic       a_valid, a_ready, b_valid, b_ready, enc_idle, enc_nextword_enable, src_b, sync_done;
  logic [7:0] a1_data, b1_data, enc_d_in1;
  logic       a1_valid, a1_ready, b1_valid, b1_ready, enc_idle1, nwe1, src_b1, sync_done1;
  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_a, exp_b;

  always #5 clk = ~clk;

  tx_link_scheduler u0 (
    .clk(clk), .rst(rst),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
    .enc_d_in(enc_d_in), .enc_idle(enc_idle), .enc_nextword_enable(enc_nextword_enable),
    .src_b(src_b), .sync_done(sync_done)
  );

  tx_link_scheduler #(.WORD_CYCLES(1)) u1 (
    .clk(clk), .rst(rst1),
    .a_data(a1_data), .a_valid(a1_valid), .a_ready(a1_ready),
    .b_data(b1_data), .b_valid(b1_valid), .b_ready(b1_ready),
    .enc_d_in(enc_d_in1), .enc_idle(enc_idle1), .enc_nextword_enable(nwe1),
    .src_b(src_b1), .sync_done(sync_done1)
  );

  // advance one cycle; a requester moves to its next byte after a completed handshake
  task automatic step();
    logic at, bt;
    at = a_valid && a_ready;
    bt = b_valid && b_ready;
    @(negedge clk);
    if (at) a_data = a_data + 8'd1;
    if (bt) b_data = b_data + 8'd1;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0; a_data = 8'h00; b_data = 8'h80;
    rst1 = 1'b0; a1_valid = 1'b0; b1_valid = 1'b0; a1_data = 8'hAA; b1_data = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({enc_d_in, enc_idle, enc_nextword_enable, a_ready, b_ready, src_b, sync_done} !== 14'b00000000_1_0_0_0_0_0)
      $display("FAIL reset_outputs got d=%h idle=%b nwe=%b ar=%b br=%b sb=%b sd=%b", enc_d_in, enc_idle,
               enc_nextword_enable, a_ready, b_ready, src_b, sync_done);
    if ({enc_d_in, enc_idle, enc_nextword_enable, a_ready, b_ready, src_b, sync_done} !== 14'b00000000_1_0_0_0_0_0)
      errors++;
  endtask

  task automatic test_sync();
    int strobes, last, first_rdy;
    strobes = 0; last = 0; first_rdy = -1;
    rst = 1'b1; a_valid = 1'b1;
    for (int c = 0; c < 100 && first_rdy < 0; c++) begin
      if (a_ready) first_rdy = c;
      if (enc_nextword_enable) begin
        strobes++;
        checks++;
        if (enc_idle !== 1'b1) begin errors++; $display("FAIL sync_idle strobe=%0d got=%b exp=1", strobes, enc_idle); end
        checks++;
        if (sync_done !== (strobes >= 4)) begin
          errors++; $display("FAIL sync_done strobe=%0d got=%b exp=%b", strobes, sync_done, strobes >= 4);
        end
        if (strobes > 1) begin
          checks++;
          if (c - last != 10) begin errors++; $display("FAIL strobe_spacing got=%0d exp=10", c - last); end
        end
        last = c;
      end
      if (first_rdy < 0) step();
    end
    checks++;
    if (first_rdy != 49) begin errors++; $display("FAIL first_a_ready cycle got=%0d exp=49", first_rdy); end
    checks++;
    if (strobes != 4) begin errors++; $display("FAIL sync_strobes got=%0d exp=4", strobes); end
    exp_a = 8'h00;
  endtask

  task automatic test_a_stream();
    int nd;
    bit done;
    nd = 0; done = 0;
    for (int c = 0; c < 4000 && !done; c++) begin
      step();
      if (enc_nextword_enable) begin
        checks++;
        if (nd == 256) begin
          if (enc_idle !== 1'b1) begin errors++; $display("FAIL forced_comma got idle=%b exp=1", enc_idle); end
        end else if ({enc_idle, src_b, enc_d_in} !== {2'b00, exp_a}) begin
          errors++;
          $display("FAIL a_stream word=%0d got idle=%b sb=%b d=%h exp idle=0 sb=0 d=%h", nd, enc_idle, src_b, enc_d_in, exp_a);
        end
        if (nd != 256) exp_a = exp_a + 8'd1;
        done = nd == 257;
        nd++;
      end
    end
    checks++;
    if (!done) begin errors++; $display("FAIL a_stream_timeout got words=%0d exp=258", nd); end
  endtask

  task automatic test_idle_fill();
    int idles;
    bit done;
    idles = 0; done = 0;
    a_valid = 1'b0;
    for (int c = 0; c < 100 && idles < 3; c++) begin
      step();
      if (enc_nextword_enable) begin
        idles++;
        checks++;
        if (enc_idle !== 1'b1) begin errors++; $display("FAIL idle_fill word=%0d got idle=%b exp=1", idles, enc_idle); end
      end
    end
    checks++;
    if (u0.comma_cnt !== '0) begin errors++; $display("FAIL idle_comma_cnt got=%0d exp=0", u0.comma_cnt); end
    a_valid = 1'b1;
    for (int c = 0; c < 20 && !done; c++) begin
      step();
      if (enc_nextword_enable) begin
        done = 1;
        checks++;
        if ({enc_idle, enc_d_in} !== {1'b0, exp_a}) begin
          errors++; $display("FAIL idle_then_a got idle=%b d=%h exp idle=0 d=%h", enc_idle, enc_d_in, exp_a);
        end
        exp_a = exp_a + 8'd1;
      end
    end
    checks++;
    if (!done) begin errors++; $display("FAIL idle_then_a_timeout got none exp strobe"); end
  endtask

  task automatic test_contention();
    int k;
    logic exp_src;
    k = 0;
    b_valid = 1'b1; exp_b = b_data;
    for (int c = 0; c < 1000 && k < 51; c++) begin
      step();
      if (enc_nextword_enable) begin
        exp_src = (k % 17) == 16;
        checks++;
        if ({enc_idle, src_b, enc_d_in} !== {1'b0, exp_src, exp_src ? exp_b : exp_a}) begin
          errors++;
          $display("FAIL contention word=%0d got idle=%b sb=%b d=%h exp idle=0 sb=%b d=%h", k, enc_idle, src_b,
                   enc_d_in, exp_src, exp_src ? exp_b : exp_a);
        end
        if (exp_src) exp_b = exp_b + 8'd1;
        else exp_a = exp_a + 8'd1;
        k++;
      end
    end
    checks++;
    if (k != 51) begin errors++; $display("FAIL contention_timeout got=%0d exp=51", k); end
    b_valid = 1'b0;
  endtask

  task automatic test_mid_reset();
    int strobes;
    bit done;
    strobes = 0; done = 0;
    repeat (5) step();
    checks++;
    if (u0.timer !== 4'd5) begin errors++; $display("FAIL mid_reset_timer got=%0d exp=5", u0.timer); end
    rst = 1'b0;
    step();
    checks++;
    if ({enc_d_in, enc_idle, enc_nextword_enable, a_ready, b_ready, src_b, sync_done} !== 14'b00000000_1_0_0_0_0_0) begin
      errors++;
      $display("FAIL mid_reset_outputs got d=%h idle=%b nwe=%b ar=%b br=%b sb=%b sd=%b", enc_d_in, enc_idle,
               enc_nextword_enable, a_ready, b_ready, src_b, sync_done);
    end
    rst = 1'b1;
    for (int c = 0; c < 200 && !done; c++) begin
      step();
      if (enc_nextword_enable) begin
        strobes++;
        if (!enc_idle) begin
          done = 1;
          checks++;
          if (enc_d_in !== exp_a) begin errors++; $display("FAIL mid_reset_data got=%h exp=%h", enc_d_in, exp_a); end
        end
      end
    end
    checks++;
    if (strobes != 5) begin errors++; $display("FAIL mid_reset_resync got first data strobe=%0d exp=5", strobes); end
  endtask

  task automatic test_word_cycles_1();
    int first_rdy;
    logic prev_rdy;
    logic [7:0] prev_byte;
    first_rdy = -1; prev_rdy = 1'b0; prev_byte = 8'h00;
    rst1 = 1'b1; a1_valid = 1'b1; a1_data = 8'hAA;
    for (int c = 0; c < 14; c++) begin
      checks++;
      if (nwe1 !== (c >= 1)) begin errors++; $display("FAIL wc1_nwe cycle=%0d got=%b exp=%b", c, nwe1, c >= 1); end
      if (prev_rdy) begin
        checks++;
        if ({enc_idle1, enc_d_in1} !== {1'b0, prev_byte}) begin
          errors++; $display("FAIL wc1_data cycle=%0d got idle=%b d=%h exp idle=0 d=%h", c, enc_idle1, enc_d_in1, prev_byte);
        end
      end
      if (a1_ready && first_rdy < 0) first_rdy = c;
      prev_rdy = a1_ready;
      prev_byte = a1_data;
      @(negedge clk);
      if (prev_rdy) a1_data = ~a1_data;
      #1;
    end
    checks++;
    if (first_rdy != 4) begin errors++; $display("FAIL wc1_first_ready got=%0d exp=4", first_rdy); end
    rst1 = 1'b0;
    #1;
    checks++;
    if (a1_ready !== 1'b0) begin errors++; $display("FAIL wc1_ready_in_reset got=%b exp=0", a1_ready); end
    @(negedge clk);
    #1;
    checks++;
    if ({enc_idle1, nwe1, sync_done1} !== 3'b100) begin
      errors++; $display("FAIL wc1_reset got idle=%b nwe=%b sd=%b exp 1 0 0", enc_idle1, nwe1, sync_done1);
    end
  endtask

  initial begin
    test_reset();
    test_sync();
    test_a_stream();
    test_idle_fill();
    test_contention();
    test_mid_reset();
    test_word_cycles_1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
